// File: rtl/readout_capture_if.sv
// Handshake bundle for readout_capture: the ADC sample request/valid pair
// and the valid/ready result stream leaving the record FIFO.
interface readout_capture_if #(
    parameter int DATA_W = 16
) ();
    logic              adc_req;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [DATA_W+3:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output adc_req,
        input  adc_data,
        input  adc_valid,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  adc_req,
        output adc_data,
        output adc_valid,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/readout_capture.sv
// Readout capture: after an M-pulse strobe, settle, take one ADC sample, threshold it,
// and queue the result record in a first-word fall-through FIFO with event counters.
module readout_capture #(
    parameter int          DATA_W    = 16,
    parameter int          TMR_W     = 22,
    parameter int          FIFO_AW   = 3,
    parameter int          CNT_W     = 32,
    parameter logic [7:0]  MEAS_MASK = 8'b0000_0101
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [7:0]         signal_in,
    input  logic               trigger,
    input  logic               verify_trigger,
    input  logic [TMR_W-1:0]   settle_dur,
    input  logic [TMR_W-1:0]   adc_timeout,
    input  logic [DATA_W-1:0]  threshold,
    readout_capture_if.master  bus,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [CNT_W-1:0]   flip_count,
    output logic [CNT_W-1:0]   missed_count,
    output logic [CNT_W-1:0]   overflow_count
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT_ADC,
        PUSH
    } state_t;

    state_t             state, state_next;
    logic [TMR_W-1:0]   timer;

    logic               meas_active;
    logic               strobe_any;
    logic               timer_clr;
    logic               timer_inc;
    logic               start;
    logic               start_kind;
    logic               capture;
    logic               set_abort;
    logic               set_timeout;
    logic               do_push;
    logic               missed_inc;

    logic               rec_kind;
    logic               rec_abort;
    logic               rec_timeout;
    logic               rec_bit;
    logic [DATA_W-1:0]  rec_sample;
    logic [DATA_W+3:0]  rec_word;
    logic               rec_good;

    logic               verify_bit;
    logic               verify_valid;

    logic [DATA_W+3:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_ok;
    logic               pop;

    assign meas_active = |(signal_in & MEAS_MASK);
    assign strobe_any  = trigger | verify_trigger;
    assign rec_word    = {rec_kind, rec_abort, rec_timeout, rec_bit, rec_sample};
    assign rec_good    = !rec_abort && !rec_timeout;

    // A dual strobe in IDLE still starts a (verify) capture but counts as one miss.
    assign missed_inc = (state != IDLE) ? strobe_any : (trigger & verify_trigger);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        start       = 1'b0;
        start_kind  = 1'b0;
        capture     = 1'b0;
        set_abort   = 1'b0;
        set_timeout = 1'b0;
        do_push     = 1'b0;
        case (state)
            IDLE: begin
                if (strobe_any) begin
                    start      = 1'b1;
                    start_kind = ~verify_trigger;
                    timer_clr  = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!meas_active) begin
                    set_abort  = 1'b1;
                    state_next = PUSH;
                end else if (timer == settle_dur) begin
                    timer_clr  = 1'b1;
                    state_next = WAIT_ADC;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            WAIT_ADC: begin
                if (bus.adc_valid) begin
                    capture    = 1'b1;
                    state_next = PUSH;
                end else if (!meas_active) begin
                    set_abort  = 1'b1;
                    state_next = PUSH;
                end else if (timer == adc_timeout) begin
                    set_timeout = 1'b1;
                    state_next  = PUSH;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            PUSH: begin
                do_push    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.adc_req = (state == WAIT_ADC);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer_inc) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Record fields are cleared on every new capture so abort/timeout records carry zero data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rec_kind    <= 1'b0;
            rec_abort   <= 1'b0;
            rec_timeout <= 1'b0;
            rec_bit     <= 1'b0;
            rec_sample  <= '0;
        end else begin
            if (start) begin
                rec_kind    <= start_kind;
                rec_abort   <= 1'b0;
                rec_timeout <= 1'b0;
                rec_bit     <= 1'b0;
                rec_sample  <= '0;
            end
            if (capture) begin
                rec_sample <= bus.adc_data;
                rec_bit    <= (bus.adc_data >= threshold);
            end
            if (set_abort) begin
                rec_abort <= 1'b1;
            end
            if (set_timeout) begin
                rec_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            verify_bit   <= 1'b0;
            verify_valid <= 1'b0;
            flip_count   <= '0;
        end else if (do_push && rec_good) begin
            if (!rec_kind) begin
                verify_bit   <= rec_bit;
                verify_valid <= 1'b1;
            end else if (verify_valid) begin
                if (rec_bit != verify_bit) begin
                    flip_count <= flip_count + CNT_W'(1);
                end
                verify_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            missed_count   <= '0;
            overflow_count <= '0;
        end else begin
            if (missed_inc) begin
                missed_count <= missed_count + CNT_W'(1);
            end
            if (do_push && fifo_full) begin
                overflow_count <= overflow_count + CNT_W'(1);
            end
        end
    end

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
    assign fifo_full  = (fifo_level == DEPTH[FIFO_AW:0]);
    assign fifo_empty = (fifo_level == '0);
    assign push_ok    = do_push && !fifo_full;
    assign pop        = !fifo_empty && bus.out_ready;

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= rec_word;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_readout_capture.sv
// Scoreboard bench for readout_capture: directed captures push expected records,
// a negedge monitor pops and compares each record the DUT hands over.
module tb_readout_capture;

    localparam int DATA_W  = 16;
    localparam int TMR_W   = 22;
    localparam int FIFO_AW = 3;
    localparam int CNT_W   = 32;

    logic               clk_in = 1'b0;
    logic               rst_n;
    logic [7:0]         signal_in;
    logic               trigger;
    logic               verify_trigger;
    logic [TMR_W-1:0]   settle_dur;
    logic [TMR_W-1:0]   adc_timeout;
    logic [DATA_W-1:0]  threshold;
    logic [FIFO_AW:0]   fifo_level;
    logic [CNT_W-1:0]   flip_count;
    logic [CNT_W-1:0]   missed_count;
    logic [CNT_W-1:0]   overflow_count;

    readout_capture_if #(.DATA_W(DATA_W)) bus ();

    readout_capture dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .signal_in      (signal_in),
        .trigger        (trigger),
        .verify_trigger (verify_trigger),
        .settle_dur     (settle_dur),
        .adc_timeout    (adc_timeout),
        .threshold      (threshold),
        .bus            (bus),
        .fifo_level     (fifo_level),
        .flip_count     (flip_count),
        .missed_count   (missed_count),
        .overflow_count (overflow_count)
    );

    always #5 clk_in = ~clk_in;

    int vec_count  = 0;
    int miss_count = 0;
    logic [DATA_W+3:0] exp_q [$];

    // Test-5 vectors: threshold 100, every record is a good verify capture
    logic [DATA_W-1:0] t5_data [9] = '{16'd10, 16'd200, 16'd99, 16'd100, 16'd101,
                                       16'd0, 16'd65535, 16'd300, 16'd77};
    logic [DATA_W+3:0] t5_rec  [9] = '{20'h0000A, 20'h100C8, 20'h00063, 20'h10064, 20'h10065,
                                       20'h00000, 20'h1FFFF, 20'h1012C, 20'h0004D};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk_in) begin
        logic [DATA_W+3:0] exp_rec;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("[TB] FAIL unexpected_record: got 0x%0h, expected no record", bus.out_data);
            end else begin
                exp_rec = exp_q.pop_front();
                checkOutput("record", {12'b0, bus.out_data}, {12'b0, exp_rec});
            end
        end
    end

    // Issues one strobe and plays the ADC; lat counts edges from the strobe-sampling
    // edge to the edge where the record lands in the FIFO (or is dropped), -1 on timeout.
    task automatic applyStimulus(input logic trig, input logic ver, input logic give_adc,
                                 input logic [DATA_W-1:0] data, input int drop_at,
                                 input logic stray_trig, input logic push_exp,
                                 input logic [DATA_W+3:0] exp_rec, output int lat);
        logic [FIFO_AW:0] prev_level;
        logic [CNT_W-1:0] prev_ovf;
        bit               given;
        lat   = -1;
        given = 0;
        if (push_exp) exp_q.push_back(exp_rec);
        @(posedge clk_in); #1;
        trigger        = trig;
        verify_trigger = ver;
        @(posedge clk_in); #1;
        trigger        = 1'b0;
        verify_trigger = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            prev_level = fifo_level;
            prev_ovf   = overflow_count;
            @(posedge clk_in); #1;
            if (fifo_level > prev_level || overflow_count != prev_ovf) begin
                lat = i;
                break;
            end
            bus.adc_valid = 1'b0;
            if (give_adc && !given && bus.adc_req) begin
                bus.adc_data  = data;
                bus.adc_valid = 1'b1;
                given         = 1;
            end
            if (i == drop_at) signal_in = 8'h00;
            trigger = stray_trig && (i == drop_at);
        end
        bus.adc_valid = 1'b0;
        trigger       = 1'b0;
        signal_in     = 8'h01;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int waited;
        rst_n          = 1'b0;
        signal_in      = 8'h01;
        trigger        = 1'b0;
        verify_trigger = 1'b0;
        settle_dur     = 22'd3;
        adc_timeout    = 22'd5;
        threshold      = 16'd100;
        bus.adc_data   = '0;
        bus.adc_valid  = 1'b0;
        bus.out_ready  = 1'b1;

        #12;
        checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset_adc_req", {31'b0, bus.adc_req}, 32'd0);
        checkOutput("reset_out_data", {12'b0, bus.out_data}, 32'd0);
        checkOutput("reset_level", {28'b0, fifo_level}, 32'd0);
        checkOutput("reset_flip", flip_count, 32'd0);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] test 1: verify capture, sample 150");
        applyStimulus(1'b0, 1'b1, 1'b1, 16'd150, 0, 1'b0, 1'b1, 20'h10096, lat);
        checkOutput("t1_latency", lat, 32'd6);
        checkOutput("t1_out_valid", {31'b0, bus.out_valid}, 32'd1);

        $display("[TB] test 2: trigger capture and flip tracking");
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd40, 0, 1'b0, 1'b1, 20'h80028, lat);
        checkOutput("t2_latency", lat, 32'd6);
        checkOutput("t2_flip", flip_count, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'd150, 0, 1'b0, 1'b1, 20'h10096, lat);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd150, 0, 1'b0, 1'b1, 20'h90096, lat);
        checkOutput("t2_flip_same", flip_count, 32'd1);

        $display("[TB] test 3: ADC timeout leaves flip tracking alone");
        applyStimulus(1'b0, 1'b1, 1'b1, 16'd40, 0, 1'b0, 1'b1, 20'h00028, lat);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 0, 1'b0, 1'b1, 20'hA0000, lat);
        checkOutput("t3_timeout_latency", lat, 32'd11);
        checkOutput("t3_flip_after_timeout", flip_count, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd150, 0, 1'b0, 1'b1, 20'h90096, lat);
        checkOutput("t3_flip_flag_kept", flip_count, 32'd2);

        $display("[TB] test 4: abort in SETTLE, stray and dual strobes");
        applyStimulus(1'b0, 1'b1, 1'b1, 16'd150, 1, 1'b1, 1'b1, 20'h40000, lat);
        checkOutput("t4_abort_latency", lat, 32'd3);
        checkOutput("t4_missed", missed_count, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'd150, 0, 1'b0, 1'b1, 20'h10096, lat);
        checkOutput("t4_dual_latency", lat, 32'd6);
        checkOutput("t4_dual_missed", missed_count, 32'd2);
        idleCycles(3);
        checkOutput("t4_drained", {28'b0, fifo_level}, 32'd0);

        $display("[TB] test 5: fill FIFO, overflow, drain in order");
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, t5_data[k], 0, 1'b0, (k < 8), t5_rec[k], lat);
            checkOutput("t5_latency", lat, 32'd6);
        end
        checkOutput("t5_level_full", {28'b0, fifo_level}, 32'd8);
        checkOutput("t5_overflow", overflow_count, 32'd1);
        checkOutput("t5_missed_unchanged", missed_count, 32'd2);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_in); #1;
            if (k == 7) checkOutput("t5_valid_before_last", {31'b0, bus.out_valid}, 32'd1);
            if (k == 8) checkOutput("t5_valid_after_drain", {31'b0, bus.out_valid}, 32'd0);
        end

        $display("[TB] test 6: reset in WAIT_ADC with entries queued");
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 16'd150, 0, 1'b0, 1'b1, 20'h10096, lat);
        end
        checkOutput("t6_level_before", {28'b0, fifo_level}, 32'd3);
        @(posedge clk_in); #1;
        verify_trigger = 1'b1;
        @(posedge clk_in); #1;
        verify_trigger = 1'b0;
        waited = 0;
        while (bus.adc_req !== 1'b1 && waited < 20) begin
            @(posedge clk_in); #1;
            waited++;
        end
        checkOutput("t6_reached_wait_adc", {31'b0, bus.adc_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("t6_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("t6_adc_req", {31'b0, bus.adc_req}, 32'd0);
        checkOutput("t6_level", {28'b0, fifo_level}, 32'd0);
        checkOutput("t6_flip", flip_count, 32'd0);
        checkOutput("t6_missed", missed_count, 32'd0);
        checkOutput("t6_overflow", overflow_count, 32'd0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd150, 0, 1'b0, 1'b1, 20'h90096, lat);
        checkOutput("t6_after_reset_latency", lat, 32'd6);
        checkOutput("t6_flip_after_reset", flip_count, 32'd0);
        idleCycles(4);
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/readout_capture.md
Name: readout_capture

Overview:
- Sits directly downstream of the pulse state machine.
- Consumes its `signal_out`, `trigger` and `verify_trigger` outputs and waits a programmable settle time inside the measure (M) pulse. It then captures one ADC sample over a valid handshake and thresholds it into a bit.
- Each result record goes into a small FIFO drained by a valid/ready consumer.
- Maintains event counters for host readout, including resistance-flip detection between the post-reset and post-write reads.

Parameters:
- DATA_W, 16, ADC sample width.
- TMR_W, 22, width of settle and timeout counters.
- FIFO_AW, 3, FIFO address width (depth = 2**FIFO_AW = 8).
- CNT_W, 32, width of event counters.
- MEAS_MASK, 8'b0000_0101, `signal_in` bits that constitute an active M pulse.

Ports:
- clk_in  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- signal_in  in  8  pulse pattern from the upstream pulse state machine.
- trigger  in  1  one-cycle strobe: M pulse after write has begun.
- verify_trigger  in  1  one-cycle strobe: M pulse after reset has begun.
- settle_dur  in  TMR_W  cycles from strobe to start of ADC wait.
- adc_timeout  in  TMR_W  maximum cycles waiting for `adc_valid`.
- threshold  in  DATA_W  bit = 1 when `adc_data` >= `threshold` (unsigned).
- adc_data  in  DATA_W  ADC sample.
- adc_valid  in  1  `adc_data` valid this cycle.
- adc_req  out  1  high while in WAIT_ADC.
- out_data  out  DATA_W+4  FIFO head record.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts head when `out_valid` & `out_ready`.
- fifo_level  out  FIFO_AW+1  entries stored.
- flip_count  out  CNT_W  post-write bit differs from preceding post-reset bit.
- missed_count  out  CNT_W  strobes ignored.
- overflow_count  out  CNT_W  records dropped on full FIFO.

Behaviour:
- **Reset.** `rst_n` low clears everything asynchronously: state=IDLE, all counters, FIFO pointers, the stored verify bit and its valid flag, and all outputs (`out_data` = 0).
- **Record layout.**
  - [DATA_W+3] kind: 1 = trigger, 0 = verify.
  - [DATA_W+2] aborted.
  - [DATA_W+1] timeout.
  - [DATA_W] bit.
  - [DATA_W-1:0] sample.
  - Sample and bit are 0 when aborted or timed out.
- **meas_active** = |(`signal_in` & MEAS_MASK).
- **IDLE:**
  - On a `trigger` or `verify_trigger` strobe: latch kind, clear the timer, go to SETTLE.
  - If both strobes arrive in the same cycle: verify wins, `missed_count`+1.
- **SETTLE:**
  - If !meas_active: aborted record, go to PUSH.
  - Else if timer == `settle_dur`: clear timer, go to WAIT_ADC.
  - Else timer+1.
  - With `settle_dur` = 0, WAIT_ADC is entered on the cycle after the strobe.
- **WAIT_ADC** (`adc_req` = 1); priority order:
  1. `adc_valid`: capture sample, bit = (sample >= `threshold`), go to PUSH.
  2. !meas_active: aborted record.
  3. Timer == `adc_timeout`: timeout record.
  4. Otherwise timer+1.
- **PUSH** (one cycle):
  - Write the record if the FIFO is not full; otherwise drop it and `overflow_count`+1.
  - Go to IDLE.
  - Fullness is evaluated before a same-cycle pop, so a push to a full FIFO drops even if `out_ready` pops that cycle.
- **Strobes outside IDLE:** any strobe in SETTLE/WAIT_ADC/PUSH is ignored and increments `missed_count` (a dual strobe counts 1).
- **Flip tracking:**
  - A good verify record stores its bit and sets the valid flag.
  - A good trigger record with the flag set compares bits: if they differ, `flip_count`+1. The flag then clears.
  - Aborted or timeout records never touch the flag or `flip_count`.
- **FIFO:**
  - First-word fall-through: `out_data` shows the head whenever `out_valid` is high.
  - Pop on `out_valid` & `out_ready`.
  - `fifo_level` changes by push − pop.
  - Pointers wrap modulo depth.
- **Counters:** wrap at 2**CNT_W.
- **Latency:** strobe to PUSH is `settle_dur` + 2 cycles + ADC wait. The record is visible on `out_valid` the cycle after PUSH.

Test Plan:
1. `settle_dur`=3, `threshold`=100; `verify_trigger` with meas_active held; `adc_valid`=1 with data 150 on first WAIT_ADC cycle -> record kind=0, bit=1, sample=150; `out_valid` rises 6 cycles after the strobe.
2. Next, `trigger` with data 40 -> record kind=1, bit=0; `flip_count`=1. A following verify/trigger pair, both reading data 150 -> `flip_count` stays 1.
3. `adc_timeout`=5, `adc_valid` never asserted -> timeout record (bits [DATA_W+1]=1, sample=0); `flip_count` and the verify flag unchanged.
4. `signal_in` drops to 0 during SETTLE -> aborted record after one PUSH cycle; a `trigger` pulsed during SETTLE -> `missed_count`=1.
5. `out_ready`=0; 9 good captures -> `fifo_level`=8, `overflow_count`=1; then drain with `out_ready`=1 -> records emerge in order, `out_valid` falls after 8 pops.
6. Assert `rst_n`=0 mid-WAIT_ADC with 3 FIFO entries -> immediately `out_valid`=0, `adc_req`=0, all counters 0; the next strobe is captured normally.
